// File: rtl/bitrf_sweep_arb_if.sv
// Bundle between the tag pipeline / sweep control / status-bit array and bitrf_sweep_arb.
// Optional macro BITRF_SWEEP_COUNT_EN adds the sw_cleared_cnt signal.
interface bitrf_sweep_arb_if #(
    parameter int INDEX_W = 13
);
    // Pipeline access: a_gnt is a same-cycle grant; an access completes in the cycle
    // where a_req=1 and a_gnt=1, and a_q is valid only then. There is no backpressure
    // beyond a_gnt, so the requester simply holds a_req until it sees a_gnt.
    logic               a_req;
    logic               a_wr;
    logic [INDEX_W-1:0] a_index;
    logic [3:0]         a_way;
    logic               a_d;
    logic               a_gnt;
    logic [3:0]         a_q;
    logic               sw_start;
    logic [3:0]         sw_way_mask;
    logic               sw_busy;
    logic               sw_done;
    logic [INDEX_W-1:0] rf_index;
    logic [3:0]         rf_way;
    logic               rf_wr;
    logic               rf_d;
    logic [3:0]         rf_q;
    logic [1:0]         sweep_state;
`ifdef BITRF_SWEEP_COUNT_EN
    logic [INDEX_W+2:0] sw_cleared_cnt;
`endif

    modport slave (
        input  a_req, a_wr, a_index, a_way, a_d, sw_start, sw_way_mask, rf_q,
        output a_gnt, a_q, sw_busy, sw_done, rf_index, rf_way, rf_wr, rf_d, sweep_state
`ifdef BITRF_SWEEP_COUNT_EN
        , output sw_cleared_cnt
`endif
    );

    modport master (
        output a_req, a_wr, a_index, a_way, a_d, sw_start, sw_way_mask, rf_q,
        input  a_gnt, a_q, sw_busy, sw_done, rf_index, rf_way, rf_wr, rf_d, sweep_state
`ifdef BITRF_SWEEP_COUNT_EN
        , input sw_cleared_cnt
`endif
    );
endinterface

// File: rtl/bitrf_sweep_arb.sv
// Single-port scheduler for the per-line status-bit array: pipeline accesses vs. bulk way-clear sweep.
// Optional macro BITRF_SWEEP_COUNT_EN adds sw_cleared_cnt (bits found set and cleared by the sweep).
module bitrf_sweep_arb #(
    parameter int ENTRIES      = 8192,
    parameter int INDEX_W      = 13,
    parameter int STARVE_LIMIT = 16
) (
    input logic             clk,
    input logic             reset,
    bitrf_sweep_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0]         STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [INDEX_W-1:0] LAST_IDX   = INDEX_W'(ENTRIES - 1);

    state_t             state, state_nxt;
    logic [INDEX_W-1:0] sweep_idx;
    logic [3:0]         mask_q;
    logic [7:0]         starve_cnt;
    logic [3:0]         cur_way;
    logic [3:0]         mask_left;
    logic               last_idx;
    logic               sweep_slot;
    logic               accept;

    // Ways are cleared lowest-first; the current way is the lowest bit still pending.
    assign cur_way    = mask_q & (~mask_q + 4'd1);
    assign mask_left  = mask_q & ~cur_way;
    assign last_idx   = (sweep_idx == LAST_IDX);
    assign sweep_slot = (state == SWEEP) && (!bus.a_req || (starve_cnt == STARVE_MAX));
    assign accept     = (state != SWEEP) && bus.sw_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.a_gnt    = bus.a_req && !sweep_slot;
        bus.a_q      = bus.rf_q;
        bus.sw_busy  = (state == SWEEP);
        bus.sw_done  = (state == DONE);
        bus.rf_index = '0;
        bus.rf_way   = 4'b0000;
        bus.rf_wr    = 1'b0;
        bus.rf_d     = 1'b0;

        if (sweep_slot) begin
            bus.rf_index = sweep_idx;
            bus.rf_way   = cur_way;
            bus.rf_wr    = 1'b1;
        end else if (bus.a_req) begin
            bus.rf_index = bus.a_index;
            bus.rf_way   = bus.a_way;
            bus.rf_wr    = bus.a_wr;
            bus.rf_d     = bus.a_d;
        end

        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = (bus.sw_way_mask != 4'b0000) ? SWEEP : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SWEEP: begin
                if (sweep_slot && last_idx && (mask_left == 4'b0000)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_idx  <= '0;
            mask_q     <= 4'b0000;
            starve_cnt <= 8'd0;
        end else if (accept) begin
            sweep_idx  <= '0;
            mask_q     <= bus.sw_way_mask;
            starve_cnt <= 8'd0;
        end else if (state == SWEEP) begin
            if (sweep_slot) begin
                starve_cnt <= 8'd0;
                if (last_idx) begin
                    sweep_idx <= '0;
                    mask_q    <= mask_left;
                end else begin
                    sweep_idx <= sweep_idx + 1'b1;
                end
            end else if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

    assign bus.sweep_state = state;

`ifdef BITRF_SWEEP_COUNT_EN
    logic [INDEX_W+2:0] cleared_cnt;

    // rf_q is the pre-write contents of the slot being cleared this cycle.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            cleared_cnt <= '0;
        end else if (sweep_slot && ((bus.rf_q & cur_way) != 4'b0000)) begin
            cleared_cnt <= cleared_cnt + 1'b1;
        end
    end

    assign bus.sw_cleared_cnt = cleared_cnt;
`endif
endmodule

// File: doc/bitrf_sweep_arb.md
Name: bitrf_sweep_arb

Overview:
- Owner and scheduler of the single port of the 8192-entry x 4-way per-line status-bit array (valid/dirty-style bits).
- Arbitrates between two sources:
  - pipeline lookup/update requester: single-cycle read or single-way bit write;
  - maintenance sweep engine: clears selected way bits across every index, for bulk invalidate or flush-clean.
- Sits between the L1 tag pipeline and the bit array. Drives the array's index/way/wr/d and receives its asynchronous q.

Parameters:
- ENTRIES, 8192: number of indices swept.
- INDEX_W, 13: index width; must satisfy ENTRIES <= 2**INDEX_W.
- STARVE_LIMIT, 16: consecutive sweep-denied cycles before the sweep is forced one slot. Legal range 1..255.

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  pipeline access request.
- a_wr  in  1  1 = write one bit, 0 = read.
- a_index  in  INDEX_W  pipeline index.
- a_way  in  4  pipeline way, one-hot.
- a_d  in  1  pipeline write data bit.
- a_gnt  out  1  combinational grant; access takes effect this cycle.
- a_q  out  4  combinational, = rf_q; valid when a_gnt=1.
- sw_start  in  1  start sweep; sampled only when sw_busy=0.
- sw_way_mask  in  4  ways to clear; captured on an accepted sw_start.
- sw_busy  out  1  sweep in progress.
- sw_done  out  1  one-cycle completion pulse.
- rf_index  out  INDEX_W  to array.
- rf_way  out  4  to array, one-hot.
- rf_wr  out  1  to array write enable.
- rf_d  out  1  to array write data.
- rf_q  in  4  from array, asynchronous read of rf_index.

Behaviour:
- State machine: IDLE, SWEEP, DONE. Reset -> IDLE.
- Reset values: sw_busy=0, sw_done=0, sweep index=0, mask register=0, starve counter=0.
- When a_req=0 outside SWEEP, the array-side outputs are rf_wr=0, rf_index=0, rf_way=0.
- IDLE:
  - a_gnt=a_req.
  - rf_index=a_index, rf_way=a_way, rf_wr=a_req&a_wr, rf_d=a_d.
  - sw_start with mask!=0: capture mask, index=0, go to SWEEP.
  - sw_start with mask==0: go to DONE directly; no writes.
- SWEEP:
  - Current way = lowest set bit of the remaining mask.
  - Sweep slot: rf_index=sweep index, rf_way=current way, rf_wr=1, rf_d=0.
  - Sweep owns the cycle when a_req=0, or when starve counter==STARVE_LIMIT. In that cycle a_gnt=0 and the counter clears.
  - Otherwise the pipeline is granted as in IDLE and the counter increments; it saturates, no wrap.
  - After each sweep write the index increments. At index ENTRIES-1 the index wraps to 0 and the current way bit is removed from the mask.
  - When the mask becomes 0, go to DONE.
- DONE: sw_done=1 and sw_busy=0 for exactly one cycle, then IDLE. Pipeline is served as in IDLE.
- sw_busy=1 exactly while in SWEEP.
- sw_start while sw_busy=1 is ignored. A new sw_start is accepted in DONE and in IDLE.
- Uncontended single-way latency: sw_start at cycle 0; writes in cycles 1..8192; sw_done in cycle 8193. Each additional way adds 8192 cycles.
- Pipeline write to an index already swept in the current way is not re-cleared. Software orders this.
- Pipeline write and sweep write never occur in the same cycle.
- Reset mid-sweep: return to IDLE; no sw_done pulse; remaining mask discarded.
- a_way must be one-hot when a_req=1; otherwise behaviour is undefined.

Optional Feature:
- Macro: BITRF_SWEEP_COUNT_EN.
- With the macro defined:
  - Output port sw_cleared_cnt[INDEX_W+2:0] is added.
  - Cleared to 0 on an accepted sw_start and on reset.
  - Increments on each sweep write where rf_q at the current way was 1.
  - Holds its value after DONE until the next start.
- Without the macro: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Pipeline only, idle: a_req=1, a_wr=1, index 0x123, way 4'b0100, d=1, then read -> a_gnt=1 same cycle; read a_q=4'b0100.
- Sweep uncontended: preset index 5 = 4'b1111; sw_start, mask 4'b0010 -> sw_busy high for 8192 cycles; sw_done at cycle 8193; index 5 reads 4'b1101.
- Multi-way and empty mask:
  - mask 4'b1001 -> 16384 sweep writes, way0 pass first, then one sw_done.
  - mask 4'b0000 -> sw_done the cycle after start; no rf_wr.
- Starvation: a_req=1 every cycle during sweep, STARVE_LIMIT=16 -> a_gnt low exactly 1 of every 17 cycles; sweep completes in 8192*17 cycles.
- Reset mid-sweep at index 100 -> next cycle sw_busy=0; sw_done never pulses; a new sw_start is accepted and restarts at index 0.
- With BITRF_SWEEP_COUNT_EN: set way2 at 37 indices, sweep mask 4'b0100 -> sw_cleared_cnt=37 after sw_done.
